// File: rtl/spi_resp_pkg.sv
// Shared opcodes and state encoding for the SPI SRAM responder.
package spi_resp_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } spi_resp_state_t;

endpackage

// File: rtl/byte_ram.sv
// True dual-port byte RAM with synchronous read and write on both ports.
module byte_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [7:0]        din_a,
  output logic [7:0]        q_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        din_b,
  output logic [7:0]        q_b
);

  logic [7:0] mem [2**ADDR_W];

  // Contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (en_a && we_a) begin
      mem[addr_a] <= din_a;
    end
    if (we_b) begin
      mem[addr_b] <= din_b;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q_a <= 8'h00;
      q_b <= 8'h00;
    end else begin
      if (en_a && !we_a) begin
        q_a <= mem[addr_a];
      end
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/spi_ram_responder.sv
// Oversampling SPI SRAM responder (sequential mode) with a backdoor port.
module spi_ram_responder
  import spi_resp_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              csb_i,
  input  logic              sclk_i,
  input  logic              si_i,
  output logic              so_o,
  output logic              busy_o,
  input  logic              bd_we_i,
  input  logic [ADDR_W-1:0] bd_addr_i,
  input  logic [7:0]        bd_data_i,
  output logic [7:0]        bd_data_o
);

  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] si_sync;
  logic                   csb_d;
  logic                   sclk_d;

  spi_resp_state_t state_reg;
  spi_resp_state_t state_next;

  logic [3:0]        bit_cnt_reg;
  logic [7:0]        rx_reg;
  logic [7:0]        tx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_flag_reg;
  logic              wr_pend_reg;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_q;

  // Chains idle at the bus idle levels so reset release never fakes an edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      csb_sync  <= '1;
      sclk_sync <= '1;
      si_sync   <= '0;
      csb_d     <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      si_sync   <= {si_sync[SYNC_STAGES-2:0], si_i};
      csb_d     <= csb_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic csb_s, si_s, csb_fall, sclk_rise, sclk_fall;
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign si_s      = si_sync[SYNC_STAGES-1];
  assign csb_fall  = !csb_s && csb_d;
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] && !sclk_d;
  assign sclk_fall = !sclk_sync[SYNC_STAGES-1] && sclk_d;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_inc;
  assign opcode     = {rx_reg[6:0], si_s};
  assign addr_shift = {addr_reg[ADDR_W-2:0], si_s};
  assign addr_inc   = addr_reg + ADDR_W'(1);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (csb_s) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (csb_fall) state_next = CMD;
        CMD: begin
          if (sclk_rise && bit_cnt_reg == 4'd7) begin
            if (opcode == OP_READ || opcode == OP_WRITE) state_next = ADDR;
            else                                         state_next = IGNORE;
          end
        end
        ADDR: begin
          if (sclk_rise && bit_cnt_reg == 4'd15) begin
            state_next = rd_flag_reg ? READ : WRITE;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy_o   = (state_reg != IDLE);
    so_o     = (state_reg == READ) && tx_reg[7];
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_reg;
    if (wr_pend_reg) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end else if (state_reg == ADDR && sclk_rise && bit_cnt_reg == 4'd15) begin
      ram_en   = 1'b1;
      ram_addr = addr_shift;
    end else if (state_reg == READ && sclk_fall && bit_cnt_reg == 4'd7) begin
      ram_en   = 1'b1;
      ram_addr = addr_inc;
    end
  end

  // Datapath; a completed write byte is committed the cycle after its 8th sample.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bit_cnt_reg <= 4'd0;
      rx_reg      <= 8'h00;
      tx_reg      <= 8'h00;
      addr_reg    <= '0;
      rd_flag_reg <= 1'b0;
      wr_pend_reg <= 1'b0;
    end else begin
      wr_pend_reg <= 1'b0;
      if (wr_pend_reg) begin
        addr_reg <= addr_inc;
      end
      if (!csb_s) begin
        case (state_reg)
          IDLE: begin
            if (csb_fall) begin
              bit_cnt_reg <= 4'd0;
              rx_reg      <= 8'h00;
              tx_reg      <= 8'h00;
              addr_reg    <= '0;
              rd_flag_reg <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              if (bit_cnt_reg == 4'd7) begin
                bit_cnt_reg <= 4'd0;
                rx_reg      <= 8'h00;
                rd_flag_reg <= (opcode == OP_READ);
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                rx_reg      <= opcode;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr_reg    <= addr_shift;
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end
          READ: begin
            if (sclk_fall) begin
              tx_reg      <= (bit_cnt_reg == 4'd0) ? ram_q : {tx_reg[6:0], 1'b0};
              bit_cnt_reg <= (bit_cnt_reg == 4'd7) ? 4'd0 : bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7) begin
                addr_reg <= addr_inc;
              end
            end
          end
          WRITE: begin
            if (sclk_rise) begin
              rx_reg <= {rx_reg[6:0], si_s};
              if (bit_cnt_reg == 4'd7) begin
                bit_cnt_reg <= 4'd0;
                wr_pend_reg <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .resetb (resetb),
    .en_a   (ram_en),
    .we_a   (ram_we),
    .addr_a (ram_addr),
    .din_a  (rx_reg),
    .q_a    (ram_q),
    .we_b   (bd_we_i && !busy_o),
    .addr_b (bd_addr_i),
    .din_b  (bd_data_i),
    .q_b    (bd_data_o)
  );

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench: SPI master model plus backdoor accesses against hand-computed values.
module tb_spi_ram_responder;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        csb = 1'b1;
  logic        sclk = 1'b1;
  logic        si = 1'b0;
  logic        so;
  logic        busy;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0;
  logic [7:0]  bd_wdata = 8'h0;
  logic [7:0]  bd_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  spi_ram_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .csb_i     (csb),
    .sclk_i    (sclk),
    .si_i      (si),
    .so_o      (so),
    .busy_o    (busy),
    .bd_we_i   (bd_we),
    .bd_addr_i (bd_addr),
    .bd_data_i (bd_wdata),
    .bd_data_o (bd_rdata)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half_period();
    repeat (6) @(negedge clk);
  endtask

  // Master drives si while sclk is low and samples so just before raising sclk.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b > 7 - nbits; b--) begin
      sclk = 1'b0;
      si   = tx[b];
      half_period();
      rx   = {rx[6:0], so};
      sclk = 1'b1;
      half_period();
    end
  endtask

  task automatic csb_low();
    csb = 1'b0;
    half_period();
  endtask

  task automatic csb_high();
    half_period();
    csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    d = bd_rdata;
  endtask

  task automatic spi_header(input logic [7:0] op, input logic [15:0] a);
    logic [7:0] dummy;
    csb_low();
    spi_xfer(op, 8, dummy);
    spi_xfer(a[15:8], 8, dummy);
    spi_xfer(a[7:0], 8, dummy);
  endtask

  logic [7:0] r0, r1, r2;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_so", {15'h0, so}, 16'h0);
    check("reset_busy", {15'h0, busy}, 16'h0);
    check("reset_bd_data", {8'h0, bd_rdata}, 16'h0);
    resetb = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0xCD, 0xAB at 0x1234
    spi_header(8'h02, 16'h1234);
    check("write_busy", {15'h0, busy}, 16'h1);
    spi_xfer(8'hCD, 8, r0);
    spi_xfer(8'hAB, 8, r1);
    check("write_so_quiet", {r0, r1}, 16'h0000);
    csb_high();
    check("write_busy_after", {15'h0, busy}, 16'h0);
    bd_read(16'h1234, r0);
    bd_read(16'h1235, r1);
    check("write_mem_1234", {8'h0, r0}, 16'h00CD);
    check("write_mem_1235", {8'h0, r1}, 16'h00AB);
    $display("[TB] write 0x1234: mem=%02h %02h", r0, r1);

    // Read word 0xA55A from 0x0010
    bd_write(16'h0010, 8'h5A);
    bd_write(16'h0011, 8'hA5);
    spi_header(8'h03, 16'h0010);
    spi_xfer(8'h00, 8, r0);
    spi_xfer(8'h00, 8, r1);
    csb_high();
    check("read_byte0", {8'h0, r0}, 16'h005A);
    check("read_byte1", {8'h0, r1}, 16'h00A5);
    check("read_word", {r1, r0}, 16'hA55A);
    check("read_so_idle", {15'h0, so}, 16'h0);
    $display("[TB] read 0x0010: word=%04h", {r1, r0});

    // Address wrap on write
    spi_header(8'h02, 16'hFFFF);
    spi_xfer(8'h11, 8, r0);
    spi_xfer(8'h22, 8, r0);
    spi_xfer(8'h33, 8, r0);
    csb_high();
    bd_read(16'hFFFF, r0);
    bd_read(16'h0000, r1);
    bd_read(16'h0001, r2);
    check("wrap_mem_ffff", {8'h0, r0}, 16'h0011);
    check("wrap_mem_0000", {8'h0, r1}, 16'h0022);
    check("wrap_mem_0001", {8'h0, r2}, 16'h0033);
    $display("[TB] wrap write 0xFFFF: %02h %02h %02h", r0, r1, r2);

    // Bad opcode; also a backdoor write attempted while busy
    bd_write(16'h0050, 8'h44);
    csb_low();
    spi_xfer(8'h05, 8, r0);
    check("bad_busy", {15'h0, busy}, 16'h1);
    bd_write(16'h0050, 8'h99);
    spi_xfer(8'hFF, 8, r0);
    spi_xfer(8'hFF, 8, r1);
    spi_xfer(8'hFF, 8, r2);
    check("bad_so_quiet", {8'h0, r0 | r1 | r2}, 16'h0000);
    csb_high();
    check("bad_busy_after", {15'h0, busy}, 16'h0);
    bd_read(16'hFFFF, r0);
    bd_read(16'h1234, r1);
    bd_read(16'h0050, r2);
    check("bad_mem_ffff", {8'h0, r0}, 16'h0011);
    check("bad_mem_1234", {8'h0, r1}, 16'h00CD);
    check("bd_write_blocked", {8'h0, r2}, 16'h0044);
    $display("[TB] bad opcode 0x05: mem ffff=%02h 1234=%02h 0050=%02h", r0, r1, r2);

    // Abort after 5 data bits
    bd_write(16'h0040, 8'h77);
    spi_header(8'h02, 16'h0040);
    spi_xfer(8'h00, 5, r0);
    csb_high();
    bd_read(16'h0040, r0);
    check("abort_mem_0040", {8'h0, r0}, 16'h0077);
    spi_header(8'h03, 16'h0040);
    spi_xfer(8'h00, 8, r1);
    csb_high();
    check("abort_readback", {8'h0, r1}, 16'h0077);
    $display("[TB] abort write 0x0040: mem=%02h read=%02h", r0, r1);

    // Reset during the second read byte
    bd_write(16'h0020, 8'h3C);
    bd_write(16'h0021, 8'hC3);
    spi_header(8'h03, 16'h0020);
    spi_xfer(8'h00, 8, r0);
    spi_xfer(8'h00, 1, r1);
    check("rst_first_byte", {8'h0, r0}, 16'h003C);
    check("rst_first_bit", {8'h0, r1}, 16'h0001);
    check("rst_so_before", {15'h0, so}, 16'h1);
    @(negedge clk);
    resetb = 1'b0;
    #2;
    check("rst_so", {15'h0, so}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    csb = 1'b1;
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (6) @(negedge clk);
    spi_header(8'h03, 16'h0020);
    spi_xfer(8'h00, 8, r0);
    spi_xfer(8'h00, 8, r1);
    csb_high();
    check("rst_reread_word", {r1, r0}, 16'hC33C);
    $display("[TB] read after reset 0x0020: word=%04h", {r1, r0});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
